aurora_hls_nfc_arbiter: RTL and testbench

Shares the single Aurora native-flow-control AXI-Stream input between N_REQ NFC word sources, e.g. per-channel RX FIFO watermark controllers plus a host-forced XON/XOFF source. It uses round-robin arbitration and keeps one word in flight at a time. An optional enforced idle gap separates consecutive NFC words. It sits between the NFC requesters and the core's NFC port.

---
 rtl/aurora_hls_nfc_pkg.sv | 17 +
 rtl/aurora_hls_rr_pick.sv | 27 ++
 rtl/aurora_hls_nfc_arbiter.sv | 154 +++++++++++++++
 tb/tb_aurora_hls_nfc_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_hls_nfc_pkg.sv
// Shared NFC constants and arbiter state encoding.
// Stats build option of the arbiter: AURORA_HLS_NFC_ARB_STATS_EN.
package aurora_hls_nfc_pkg;

  localparam int NFC_W = 16;
  localparam int GAP_W = 8;

  localparam logic [NFC_W-1:0] NFC_XOFF = 16'hFFFF;
  localparam logic [NFC_W-1:0] NFC_XON  = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } nfc_state_e;

endpackage

// File: rtl/aurora_hls_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Zero latency, no state, no backpressure.
module aurora_hls_rr_pick #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  always_comb begin
    int idx;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!any_req && req[idx]) begin
        any_req   = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/aurora_hls_nfc_arbiter.sv
// Round-robin arbiter of N_REQ NFC word sources onto one AXI-S NFC port, one word in flight,
// grant one cycle after valid, holds word under tready backpressure; stats via AURORA_HLS_NFC_ARB_STATS_EN.
module aurora_hls_nfc_arbiter
  import aurora_hls_nfc_pkg::*;
#(
  parameter  int N_REQ      = 2,
  parameter  int GAP_CYCLES = 4,
  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [NFC_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   m_axi_nfc_tvalid,
  output logic [0:NFC_W-1]       m_axi_nfc_tdata,
  input  logic                   m_axi_nfc_tready,
`ifdef AURORA_HLS_NFC_ARB_STATS_EN
  input  logic                   counter_reset,
  output logic [32*N_REQ-1:0]    grant_count,
  output logic [31:0]            wait_count,
`endif
  output logic                   busy,
  output logic [IDX_W-1:0]       last_grant
);

  nfc_state_e       state_q, state_d;
  logic             tvalid_q, tvalid_d;
  logic [NFC_W-1:0] tdata_q, tdata_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  aurora_hls_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    req_ready_d  = '0;
    last_grant_d = last_grant_q;
    ptr_d        = ptr_q;
    gap_d        = gap_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          tdata_d      = req_data[NFC_W*int'(pick_idx) +: NFC_W];
          tvalid_d     = 1'b1;
          req_ready_d  = N_REQ'(1) << pick_idx;
          last_grant_d = pick_idx;
          ptr_d        = (int'(pick_idx) == N_REQ-1) ? '0 : pick_idx + IDX_W'(1);
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        if (tvalid_q && m_axi_nfc_tready) begin
          tvalid_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = GAP_W'(GAP_CYCLES);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // Counter reaching 1 ends the gap, so GAP lasts exactly GAP_CYCLES cycles.
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        gap_d    = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      req_ready_q  <= '0;
      last_grant_q <= '0;
      ptr_q        <= '0;
      gap_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      req_ready_q  <= req_ready_d;
      last_grant_q <= last_grant_d;
      ptr_q        <= ptr_d;
      gap_q        <= gap_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign m_axi_nfc_tvalid = tvalid_q;
  assign m_axi_nfc_tdata  = tdata_q;
  assign busy             = busy_q;
  assign last_grant       = last_grant_q;

`ifdef AURORA_HLS_NFC_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]            wait_cnt_q, wait_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (counter_reset) begin
      grant_cnt_d = '0;
      wait_cnt_d  = '0;
    end else begin
      if (state_q == S_IDLE && pick_any)
        grant_cnt_d[pick_idx] = grant_cnt_q[pick_idx] + 32'd1;
      if (|req_valid && state_q != S_IDLE)
        wait_cnt_d = wait_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign grant_count = grant_cnt_q;
  assign wait_count  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_aurora_hls_nfc_arbiter.sv
// Directed bench for aurora_hls_nfc_arbiter with a grant/word scoreboard; stats checks when
// AURORA_HLS_NFC_ARB_STATS_EN is defined.
module tb_aurora_hls_nfc_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_valid2;
  logic [31:0] req_data, req_data2;
  logic [1:0]  req_ready, req_ready2;
  logic        m_tvalid, m_tvalid2;
  logic [0:15] m_tdata, m_tdata2;
  logic        m_tready, m_tready2;
  logic        busy, busy2;
  logic [0:0]  last_grant, last_grant2;
`ifdef AURORA_HLS_NFC_ARB_STATS_EN
  logic        counter_reset;
  logic [63:0] grant_count, grant_count2;
  logic [31:0] wait_count, wait_count2;
  logic        counter_reset2;
`endif

  aurora_hls_nfc_arbiter #(.N_REQ(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .m_axi_nfc_tvalid(m_tvalid), .m_axi_nfc_tdata(m_tdata), .m_axi_nfc_tready(m_tready),
`ifdef AURORA_HLS_NFC_ARB_STATS_EN
    .counter_reset(counter_reset), .grant_count(grant_count), .wait_count(wait_count),
`endif
    .busy(busy), .last_grant(last_grant)
  );

  aurora_hls_nfc_arbiter #(.N_REQ(2), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
    .m_axi_nfc_tvalid(m_tvalid2), .m_axi_nfc_tdata(m_tdata2), .m_axi_nfc_tready(m_tready2),
`ifdef AURORA_HLS_NFC_ARB_STATS_EN
    .counter_reset(counter_reset2), .grant_count(grant_count2), .wait_count(wait_count2),
`endif
    .busy(busy2), .last_grant(last_grant2)
  );

  typedef struct packed {
    logic [7:0]  idx;
    logic [15:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   rise_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic tvalid_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while ((busy !== 1'b0 || m_tvalid !== 1'b0) && c < 40) begin
      tick();
      c++;
    end
    chk(tag, {31'd0, (c < 40)}, 32'd1);
  endtask

  // Scoreboard: each accepted word must match the oldest expected grant.
  always @(negedge clk) begin
    if (m_tvalid && !tvalid_prev) rise_q.push_back(cyc);
    tvalid_prev = m_tvalid;
    if (!rst && m_tvalid && m_tready) begin
      n_tests++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected observed=%0h expected=none", m_tdata);
      end
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_tdata", {16'd0, m_tdata}, {16'd0, e.dat});
        chk("sb_grant", {31'd0, last_grant}, {24'd0, e.idx});
      end
    end
  end

  initial begin
    int grants;
    rst = 1'b1; req_valid = '0; req_data = '0; m_tready = 1'b0;
    req_valid2 = '0; req_data2 = '0; m_tready2 = 1'b1;
`ifdef AURORA_HLS_NFC_ARB_STATS_EN
    counter_reset = 1'b0; counter_reset2 = 1'b0;
`endif
    tick(); tick();
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", {16'd0, m_tdata}, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_last", {31'd0, last_grant}, 32'd0);
    rst = 1'b0;

    // 1: single word, one handshake, 1+4 busy cycles
    req_valid = 2'b01; req_data = {16'h0000, 16'hFFFF}; m_tready = 1'b1;
    sb_q.push_back('{idx: 8'd0, dat: 16'hFFFF});
    tick();
    chk("t1_ready", {30'd0, req_ready}, 32'd1);
    chk("t1_tvalid", {31'd0, m_tvalid}, 32'd1);
    chk("t1_tdata", {16'd0, m_tdata}, 32'h0000FFFF);
    chk("t1_busy_send", {31'd0, busy}, 32'd1);
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_busy_gap", {30'd0, busy, m_tvalid}, 32'd2);
    end
    tick();
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // 2: fairness with both requesters continuously valid; pointer restarts at 0 after reset
    rst = 1'b1; tick(); rst = 1'b0;
    rise_q.delete();
    req_valid = 2'b11; req_data = {16'h0000, 16'hFFFF};
    for (int i = 0; i < 6; i++)
      sb_q.push_back('{idx: 8'(i % 2), dat: (i % 2 == 0) ? 16'hFFFF : 16'h0000});
    grants = 0;
    for (int c = 0; c < 100 && grants < 6; c++) begin
      tick();
      if (req_ready != 2'b00) begin
        chk("t2_last_grant", {31'd0, last_grant}, 32'(grants % 2));
        grants++;
      end
    end
    req_valid = 2'b00;
    chk("t2_grants", 32'(grants), 32'd6);
    wait_idle("t2_idle");
    chk("t2_rises", 32'(rise_q.size()), 32'd6);
    for (int i = 1; i < rise_q.size(); i++)
      chk("t2_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'd6);

    // 3: backpressure holds the word and blocks further grants
    req_valid = 2'b10; req_data = {16'h5A5A, 16'hFFFF}; m_tready = 1'b0;
    sb_q.push_back('{idx: 8'd1, dat: 16'h5A5A});
    tick();
    chk("t3_ready", {30'd0, req_ready}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold", {13'd0, m_tvalid, req_ready, m_tdata}, {13'd0, 1'b1, 2'b00, 16'h5A5A});
    end
    m_tready = 1'b1; req_valid = 2'b00;
    tick();
    chk("t3_after_hs", {14'd0, busy, m_tvalid, m_tdata}, {14'd0, 1'b1, 1'b0, 16'h5A5A});
    wait_idle("t3_idle");

    // 4: zero-gap build grants every other cycle with IDLE in between
    req_valid2 = 2'b01; req_data2 = {16'h0000, 16'h1234};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_send", {13'd0, m_tvalid2, busy2, req_ready2, m_tdata2},
          {13'd0, 1'b1, 1'b1, 2'b01, 16'h1234});
      tick();
      chk("t4_idle", {30'd0, m_tvalid2, busy2}, 32'd0);
    end
    req_valid2 = 2'b00;

    // 5: reset in the second SEND cycle discards the word and rewinds the pointer
    req_valid = 2'b01; req_data = {16'h0000, 16'hFFFF}; m_tready = 1'b0;
    sb_q.push_back('{idx: 8'd0, dat: 16'hFFFF});
    tick();
    chk("t5_ready", {30'd0, req_ready}, 32'd1);
    tick();
    chk("t5_send2", {31'd0, m_tvalid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t5_rst", {28'd0, m_tvalid, busy, last_grant, req_ready != 2'b00}, 32'd0);
    sb_q.delete();
    rst = 1'b0; req_valid = 2'b11; m_tready = 1'b1;
    sb_q.push_back('{idx: 8'd0, dat: 16'hFFFF});
    tick();
    chk("t5_regrant", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    wait_idle("t5_idle");

`ifdef AURORA_HLS_NFC_ARB_STATS_EN
    // 6: statistics counters
    rst = 1'b1; tick(); rst = 1'b0;
    req_data = {16'h0000, 16'hFFFF};
    for (int g = 0; g < 3; g++) begin
      req_valid = 2'b10;
      sb_q.push_back('{idx: 8'd1, dat: 16'h0000});
      tick();
      chk("t6_ready", {30'd0, req_ready}, 32'd2);
      if (g < 2) begin
        req_valid = 2'b00;
        wait_idle("t6_idle");
      end else begin
        for (int i = 0; i < 5; i++) tick();
        req_valid = 2'b00;
        chk("t6_idle_after_wait", {31'd0, busy}, 32'd0);
      end
    end
    chk("t6_grant1", grant_count[63:32], 32'd3);
    chk("t6_grant0", grant_count[31:0], 32'd0);
    chk("t6_wait", wait_count, 32'd5);
    req_valid = 2'b01;
    sb_q.push_back('{idx: 8'd0, dat: 16'hFFFF});
    tick();
    chk("t6_grant0_inc", grant_count[31:0], 32'd1);
    counter_reset = 1'b1;
    tick();
    counter_reset = 1'b0; req_valid = 2'b00;
    chk("t6_clr_grant", grant_count[31:0] | grant_count[63:32], 32'd0);
    chk("t6_clr_wait", wait_count, 32'd0);
    wait_idle("t6_idle_end");
`endif

    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
